// File: rtl/rns_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rns_pkg
// Description : Shared constants, FSM state type and modular-inverse helper
//               for the RNS (8,7,5,3) reverse converter.
//               RNS_M1..RNS_M4  default moduli
//               RNS_M           dynamic range product (840)
//               RNS_HALF_M      signed split point (420)
//               mrc_state_t     converter FSM states
//               mod_inv(a, m)   constant function: multiplicative inverse of
//                               a modulo m (0 if none exists)
// Revision    : 1.0 - initial release
// ============================================================================
package rns_pkg;

  localparam int RNS_M1     = 8;
  localparam int RNS_M2     = 7;
  localparam int RNS_M3     = 5;
  localparam int RNS_M4     = 3;
  localparam int RNS_M      = RNS_M1 * RNS_M2 * RNS_M3 * RNS_M4;
  localparam int RNS_HALF_M = RNS_M / 2;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    D1   = 3'd1,
    D2   = 3'd2,
    D3   = 3'd3,
    OUT  = 3'd4
  } mrc_state_t;

  // Brute-force search; only ever evaluated at elaboration on tiny moduli.
  function automatic int mod_inv(input int a, input int m);
    int result;
    result = 0;
    for (int i = 1; i < m; i++) begin
      if (result == 0 && ((a * i) % m) == 1) begin
        result = i;
      end
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rns_mrc_step.sv
`default_nettype none
// ============================================================================
// Module      : rns_mrc_step
// Description : One mixed-radix elimination step, purely combinational:
//                 res = ((r - a mod MJ) mod MJ) * INV mod MJ
//               Both operands are first reduced mod MJ so that out-of-range
//               residues still give a deterministic result.
// Parameters  : RES_W  residue width
//               MJ     modulus of this residue channel
//               INV    inverse of the eliminated modulus, mod MJ
// Ports       : r    in   RES_W  residue being updated
//               a    in   RES_W  mixed-radix digit being removed
//               res  out  RES_W  updated residue, always < MJ
// Revision    : 1.0 - initial release
// ============================================================================
module rns_mrc_step #(
  parameter int RES_W = 3,
  parameter int MJ    = 7,
  parameter int INV   = 1
) (
  input  logic [RES_W-1:0] r,
  input  logic [RES_W-1:0] a,
  output logic [RES_W-1:0] res
);

  localparam int D_W = RES_W + 1;
  localparam int P_W = 2 * RES_W + 2;

  localparam logic [D_W-1:0] C_MJ_D  = D_W'(MJ);
  localparam logic [P_W-1:0] C_MJ_P  = P_W'(MJ);
  localparam logic [P_W-1:0] C_INV_P = P_W'(INV);

  logic [D_W-1:0] w_r_mod;
  logic [D_W-1:0] w_a_mod;
  logic [D_W-1:0] w_diff;
  logic [P_W-1:0] w_prod;

  always_comb begin
    w_r_mod = D_W'(r) % C_MJ_D;
    w_a_mod = D_W'(a) % C_MJ_D;
    // Modular subtraction: add MJ back when the plain difference would wrap.
    if (w_r_mod >= w_a_mod) begin
      w_diff = w_r_mod - w_a_mod;
    end else begin
      w_diff = w_r_mod + C_MJ_D - w_a_mod;
    end
    w_prod = P_W'(w_diff) * C_INV_P;
    res    = RES_W'(w_prod % C_MJ_P);
  end

endmodule
`default_nettype wire

// File: rtl/rns2bin_mrc.sv
`default_nettype none
// ============================================================================
// Module      : rns2bin_mrc
// Description : RNS (8,7,5,3) to signed binary reverse converter using
//               iterative mixed-radix conversion. One word in flight at a
//               time; result appears 3 clock edges after acceptance.
//               Build option RNS_RANGE_CHECK_EN: flag residues >= modulus,
//               reporting out_err=1 / out_data=0 for that word.
// Ports       : clk        in   1      clock, rising edge
//               reset      in   1      asynchronous, active-low reset
//               in_valid   in   1      residue word valid
//               in_ready   out  1      converter idle, can accept
//               in_r1..4   in   RES_W  residues mod M1..M4
//               out_valid  out  1      result valid
//               out_ready  in   1      downstream accepts result
//               out_data   out  OUT_W  signed result in [-M/2, M/2-1]
//               out_err    out  1      residue range error
// Revision    : 1.0 - initial release
// ============================================================================
module rns2bin_mrc
  import rns_pkg::*;
#(
  parameter int M1    = RNS_M1,
  parameter int M2    = RNS_M2,
  parameter int M3    = RNS_M3,
  parameter int M4    = RNS_M4,
  parameter int RES_W = 3,
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [RES_W-1:0] in_r1,
  input  logic [RES_W-1:0] in_r2,
  input  logic [RES_W-1:0] in_r3,
  input  logic [RES_W-1:0] in_r4,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_err
);

  localparam int C_M      = M1 * M2 * M3 * M4;
  localparam int C_HALF_M = C_M / 2;

  // Inverse of the eliminated modulus within each remaining channel.
  localparam int C_INV_12 = mod_inv(M1 % M2, M2);
  localparam int C_INV_13 = mod_inv(M1 % M3, M3);
  localparam int C_INV_14 = mod_inv(M1 % M4, M4);
  localparam int C_INV_23 = mod_inv(M2 % M3, M3);
  localparam int C_INV_24 = mod_inv(M2 % M4, M4);
  localparam int C_INV_34 = mod_inv(M3 % M4, M4);

  mrc_state_t       r_state;
  // Residue registers are updated in place; after stage k, r_rk holds digit ak.
  logic [RES_W-1:0] r_r1;
  logic [RES_W-1:0] r_r2;
  logic [RES_W-1:0] r_r3;
  logic [RES_W-1:0] r_r4;

  logic [RES_W-1:0] w_s12, w_s13, w_s14;
  logic [RES_W-1:0] w_s23, w_s24;
  logic [RES_W-1:0] w_s34;

  int               w_x;
  logic [OUT_W-1:0] w_result;
  logic [OUT_W-1:0] w_data_now;
  logic             w_err_now;

  assign in_ready = (r_state == IDLE);

  // Stage D1: remove a1 from channels 2..4
  rns_mrc_step #(.RES_W(RES_W), .MJ(M2), .INV(C_INV_12)) u_step_12 (
    .r(r_r2), .a(r_r1), .res(w_s12)
  );
  rns_mrc_step #(.RES_W(RES_W), .MJ(M3), .INV(C_INV_13)) u_step_13 (
    .r(r_r3), .a(r_r1), .res(w_s13)
  );
  rns_mrc_step #(.RES_W(RES_W), .MJ(M4), .INV(C_INV_14)) u_step_14 (
    .r(r_r4), .a(r_r1), .res(w_s14)
  );

  // Stage D2: remove a2 from channels 3..4
  rns_mrc_step #(.RES_W(RES_W), .MJ(M3), .INV(C_INV_23)) u_step_23 (
    .r(r_r3), .a(r_r2), .res(w_s23)
  );
  rns_mrc_step #(.RES_W(RES_W), .MJ(M4), .INV(C_INV_24)) u_step_24 (
    .r(r_r4), .a(r_r2), .res(w_s24)
  );

  // Stage D3: remove a3 from channel 4, leaving digit a4
  rns_mrc_step #(.RES_W(RES_W), .MJ(M4), .INV(C_INV_34)) u_step_34 (
    .r(r_r4), .a(r_r3), .res(w_s34)
  );

  // Weighted mixed-radix sum, then fold the upper half onto negatives.
  always_comb begin
    w_x = int'(r_r1)
        + int'(r_r2) * M1
        + int'(r_r3) * (M1 * M2)
        + int'(w_s34) * (M1 * M2 * M3);
    if (w_x >= C_HALF_M) begin
      w_result = OUT_W'(w_x - C_M);
    end else begin
      w_result = OUT_W'(w_x);
    end
  end

`ifdef RNS_RANGE_CHECK_EN
  logic r_range_err;
  logic w_in_range_err;

  assign w_in_range_err = (int'(in_r1) >= M1) || (int'(in_r2) >= M2) ||
                          (int'(in_r3) >= M3) || (int'(in_r4) >= M4);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_range_err <= 1'b0;
    end else if (r_state == IDLE && in_valid) begin
      r_range_err <= w_in_range_err;
    end
  end

  assign w_err_now  = r_range_err;
  assign w_data_now = r_range_err ? '0 : w_result;
`else
  assign w_err_now  = 1'b0;
  assign w_data_now = w_result;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_r1      <= '0;
      r_r2      <= '0;
      r_r3      <= '0;
      r_r4      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_r1    <= in_r1;
            r_r2    <= in_r2;
            r_r3    <= in_r3;
            r_r4    <= in_r4;
            r_state <= D1;
          end
        end
        D1: begin
          r_r2    <= w_s12;
          r_r3    <= w_s13;
          r_r4    <= w_s14;
          r_state <= D2;
        end
        D2: begin
          r_r3    <= w_s23;
          r_r4    <= w_s24;
          r_state <= D3;
        end
        D3: begin
          r_r4      <= w_s34;
          out_data  <= w_data_now;
          out_err   <= w_err_now;
          out_valid <= 1'b1;
          r_state   <= OUT;
        end
        OUT: begin
          // out_data/out_err hold their value through and after the handshake.
          if (out_ready) begin
            out_valid <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rns2bin_mrc.sv
`default_nettype none
// ============================================================================
// Module      : tb_rns2bin_mrc
// Description : Self-checking bench for rns2bin_mrc. A CRT search model
//               predicts each result from the accepted residues; a negedge
//               monitor compares every valid output cycle against it and
//               checks latency and backpressure behaviour. Directed cases,
//               a full signed round trip and randomized traffic drive it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rns2bin_mrc;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_r1, in_r2, in_r3, in_r4;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_err;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    int data;
    bit err;
    bit dc;    // data is unspecified for this word
    int acc;   // clock edge number of acceptance
  } exp_t;

  exp_t q[$];
  bit   prev_valid = 1'b0;

  rns2bin_mrc dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_r1     (in_r1),
    .in_r2     (in_r2),
    .in_r3     (in_r3),
    .in_r4     (in_r4),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input bit ok, input string name, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: find the unique X in [0,M) matching all residues by search.
  function automatic exp_t model(input int r1, input int r2, input int r3, input int r4, input int acc);
    exp_t e;
    e.acc  = acc;
    e.data = 0;
    e.err  = 1'b0;
    e.dc   = 1'b0;
    if (r1 >= 8 || r2 >= 7 || r3 >= 5 || r4 >= 3) begin
`ifdef RNS_RANGE_CHECK_EN
      e.err = 1'b1;
`else
      e.dc  = 1'b1;
`endif
    end else begin
      for (int x = 0; x < 840; x++) begin
        if (x % 8 == r1 && x % 7 == r2 && x % 5 == r3 && x % 3 == r4) begin
          e.data = (x >= 420) ? x - 840 : x;
        end
      end
    end
    return e;
  endfunction

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!reset) begin
      check(!out_valid, "valid_in_reset", out_valid, 0);
      q.delete();
    end else begin
      if (out_valid) begin
        check(!in_ready, "in_ready_while_out", in_ready, 0);
        if (q.size() == 0) begin
          check(1'b0, "spurious_valid", out_valid, 0);
        end else begin
          if (!prev_valid) begin
            check(cyc - q[0].acc == 3, "latency", cyc - q[0].acc, 3);
          end
          if (!q[0].dc) begin
            check($signed(out_data) == q[0].data, "out_data", $signed(out_data), q[0].data);
          end
          check(out_err == q[0].err, "out_err", out_err, q[0].err);
          if (out_ready) void'(q.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(model(int'(in_r1), int'(in_r2), int'(in_r3), int'(in_r4), cyc + 1));
      end
    end
    prev_valid = out_valid;
  end

  // Send one word, hold out_ready low for 'stall' valid cycles, then accept.
  task automatic send(input int r1, input int r2, input int r3, input int r4,
                      input int stall, output int d, output bit e);
    int k;
    in_r1    = 3'(r1);
    in_r2    = 3'(r2);
    in_r3    = 3'(r3);
    in_r4    = 3'(r4);
    in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    check(in_ready, "accept_timeout", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 10) begin
      @(posedge clk); #1;
      k++;
    end
    check(out_valid, "valid_timeout", out_valid, 1);
    d = $signed(out_data);
    e = out_err;
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      check($signed(out_data) == d && out_valid, "stall_hold", $signed(out_data), d);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check(!out_valid, "valid_drop", out_valid, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   d;
    bit   e;
    exp_t m;
    int   x;

    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_r1 = '0; in_r2 = '0; in_r3 = '0; in_r4 = '0;

    // Reset state
    #2;
    check(!out_valid, "rst_out_valid", out_valid, 0);
    check(out_data == 32'd0, "rst_out_data", out_data, 0);
    check(!out_err, "rst_out_err", out_err, 0);
    check(in_ready, "rst_in_ready", in_ready, 1);
    #20;
    reset = 1'b1;

    // Pin the model to hand-computed values
    m = model(3, 6, 4, 2, 0); check(m.data == 419,  "model_419",  m.data, 419);
    m = model(7, 6, 4, 2, 0); check(m.data == -1,   "model_m1",   m.data, -1);
    m = model(4, 0, 0, 0, 0); check(m.data == -420, "model_m420", m.data, -420);
    m = model(1, 1, 1, 1, 0); check(m.data == 1,    "model_1",    m.data, 1);

    @(posedge clk); #1;

    // Directed values
    send(0, 0, 0, 0, 0, d, e);
    check(d == 0 && !e, "zero", d, 0);
    send(3, 6, 4, 2, 0, d, e);
    check(d == 419, "max_pos", d, 419);
    send(7, 6, 4, 2, 1, d, e);
    check(out_data == 32'hFFFF_FFFF, "minus_one", out_data, 32'hFFFF_FFFF);
    send(4, 0, 0, 0, 0, d, e);
    check(d == -420, "min_neg", d, -420);

    // Backpressure
    send(5, 5, 0, 2, 3, d, e);
    check(d == 5, "backpressure", d, 5);
    check(d == $signed(out_data), "hold_after_hs", $signed(out_data), d);

    // Reset during D2 aborts the conversion
    in_r1 = 3'd3; in_r2 = 3'd6; in_r3 = 3'd4; in_r4 = 3'd2;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check(!out_valid, "abort_valid", out_valid, 0);
    check(in_ready, "abort_idle", in_ready, 1);
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
    @(posedge clk); #1;
    check(!out_valid, "abort_no_result", out_valid, 0);
    send(3, 6, 4, 2, 0, d, e);
    check(d == 419, "after_abort", d, 419);

    // Out-of-range residue
    send(0, 7, 0, 0, 0, d, e);
`ifdef RNS_RANGE_CHECK_EN
    check(e && d == 0, "range_err", {e, d}, {1'b1, 32'd0});
`else
    check(!e, "no_range_err", e, 0);
`endif
    send(1, 1, 1, 1, 0, d, e);
    check(d == 1 && !e, "post_err_word", d, 1);

    // Round trip over the whole signed range
    for (int n = -420; n < 420; n++) begin
      x = (n < 0) ? n + 840 : n;
      send(x % 8, x % 7, x % 5, x % 3, 0, d, e);
      check(d == n, "roundtrip", d, n);
    end

    // Randomized traffic with random stalls and idle gaps
    for (int i = 0; i < 60; i++) begin
      x = int'($urandom_range(0, 839));
      send(x % 8, x % 7, x % 5, x % 3, int'($urandom_range(0, 3)), d, e);
      check(d == ((x >= 420) ? x - 840 : x), "random", d, (x >= 420) ? x - 840 : x);
      repeat (int'($urandom_range(0, 2))) @(posedge clk);
      #1;
    end

    repeat (3) @(posedge clk);
    #1;
    check(q.size() == 0, "drain", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
